// File: rtl/mod4_count_monitor.sv
// Monitors the 2-bit count of an upstream mod-4 counter: one-hot phase, wrap pulse/count, sticky sequence error.
// Latency: every output reflects the sample taken on the previous rising edge with count_vld=1.
// Backpressure: none; samples are taken only when count_vld=1, and all state holds otherwise.
// Optional build macro MOD4_MON_SAT_EN: wrap_count saturates at all-ones instead of wrapping modulo 2**WRAP_W.
module mod4_count_monitor #(
    parameter int WRAP_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        count_in,
    input  logic              count_vld,
    input  logic              err_clr,
    output logic [3:0]        phase_onehot,
    output logic              wrap_pulse,
    output logic [WRAP_W-1:0] wrap_count,
    output logic              seq_err,
    output logic [1:0]        fsm_state
);

    // FSM encodings; 2'b11 is unused and falls back to SYNC
    localparam logic [1:0] ST_SYNC  = 2'b00;
    localparam logic [1:0] ST_TRACK = 2'b01;
    localparam logic [1:0] ST_FAULT = 2'b10;

    logic [1:0]        r_state;
    logic [1:0]        r_prev_count;
    logic [3:0]        r_phase;
    logic              r_wrap_pulse;
    logic [WRAP_W-1:0] r_wrap_count;
    logic              r_seq_err;

    logic [1:0]        w_next_state;
    logic [1:0]        w_delta;
    logic              w_checking;
    logic              w_wrap;
    logic              w_err_set;
    logic              w_cnt_full;
    logic [WRAP_W-1:0] w_wrap_count_next;

    // Wrapping 2-bit distance from the previous sample: 0 hold, 1 advance, 2/3 illegal
    assign w_delta = count_in - r_prev_count;

    // A clearing cycle is never checked, even when the sample is valid
    assign w_checking = count_vld && !err_clr && (r_state == ST_TRACK);

    // State register: synchronous reset overrides everything
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_SYNC;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic: err_clr from any state wins over an illegal step
    always_comb begin
        w_next_state = r_state;
        if (err_clr) begin
            w_next_state = ST_SYNC;
        end else begin
            case (r_state)
                ST_SYNC: begin
                    if (count_vld) begin
                        w_next_state = ST_TRACK;
                    end
                end
                ST_TRACK: begin
                    if (count_vld && w_delta[1]) begin
                        w_next_state = ST_FAULT;
                    end
                end
                ST_FAULT: begin
                    w_next_state = ST_FAULT;
                end
                default: begin
                    w_next_state = ST_SYNC;
                end
            endcase
        end
    end

    // Output decode: wrap and error events qualified by the current state
    always_comb begin
        w_wrap    = 1'b0;
        w_err_set = 1'b0;
        if (w_checking) begin
            // delta=1 from prev=3 can only land on 0, so that is exactly the 3->0 wrap
            w_wrap    = (w_delta == 2'd1) && (r_prev_count == 2'd3);
            w_err_set = w_delta[1];
        end
    end

    assign w_cnt_full = (r_wrap_count == {WRAP_W{1'b1}});

    // Wrap counter next value; only the all-ones case differs between builds
    always_comb begin
        w_wrap_count_next = r_wrap_count;
        if (w_wrap) begin
`ifdef MOD4_MON_SAT_EN
            if (!w_cnt_full) begin
                w_wrap_count_next = r_wrap_count + WRAP_W'(1);
            end
`else
            w_wrap_count_next = r_wrap_count + WRAP_W'(1);
`endif
        end
    end

    // Sample path: previous count and phase follow every valid sample in all states
    always_ff @(posedge clk) begin
        if (reset) begin
            r_prev_count <= 2'd0;
            r_phase      <= 4'b0000;
        end else if (count_vld) begin
            r_prev_count <= count_in;
            r_phase      <= 4'b0001 << count_in;
        end
    end

    // Event registers: one-cycle wrap pulse, wrap counter, sticky error
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wrap_pulse <= 1'b0;
            r_wrap_count <= '0;
            r_seq_err    <= 1'b0;
        end else begin
            r_wrap_pulse <= w_wrap;
            r_wrap_count <= w_wrap_count_next;
            if (err_clr) begin
                r_seq_err <= 1'b0;
            end else if (w_err_set) begin
                r_seq_err <= 1'b1;
            end
        end
    end

    assign phase_onehot = r_phase;
    assign wrap_pulse   = r_wrap_pulse;
    assign wrap_count   = r_wrap_count;
    assign seq_err      = r_seq_err;
    assign fsm_state    = r_state;

endmodule

// File: tb/tb_mod4_count_monitor.sv
// Directed bench for mod4_count_monitor: an 8-bit wrap counter instance plus a 2-bit one sharing stimulus.
`timescale 1ns/1ps
module tb_mod4_count_monitor;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] count_in;
    logic       count_vld;
    logic       err_clr;

    logic [3:0] phase_onehot;
    logic       wrap_pulse;
    logic [7:0] wrap_count;
    logic       seq_err;
    logic [1:0] fsm_state;

    logic [3:0] s_phase_onehot;
    logic       s_wrap_pulse;
    logic [1:0] s_wrap_count;
    logic       s_seq_err;
    logic [1:0] s_fsm_state;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    mod4_count_monitor #(.WRAP_W(8)) dut (
        .clk(clk), .reset(reset), .count_in(count_in), .count_vld(count_vld), .err_clr(err_clr),
        .phase_onehot(phase_onehot), .wrap_pulse(wrap_pulse), .wrap_count(wrap_count),
        .seq_err(seq_err), .fsm_state(fsm_state)
    );

    mod4_count_monitor #(.WRAP_W(2)) dut_small (
        .clk(clk), .reset(reset), .count_in(count_in), .count_vld(count_vld), .err_clr(err_clr),
        .phase_onehot(s_phase_onehot), .wrap_pulse(s_wrap_pulse), .wrap_count(s_wrap_count),
        .seq_err(s_seq_err), .fsm_state(s_fsm_state)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Drive one cycle of inputs, then sample 1ns after the rising edge
    task automatic cyc(input logic rst, input logic vld, input logic [1:0] cnt, input logic clr);
        reset     = rst;
        count_vld = vld;
        count_in  = cnt;
        err_clr   = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string tag, input logic [3:0] ph, input logic pl,
                           input logic [7:0] wc, input logic er, input logic [1:0] st);
        chk({tag, ".phase"}, 32'(phase_onehot), 32'(ph));
        chk({tag, ".pulse"}, 32'(wrap_pulse),   32'(pl));
        chk({tag, ".wcnt"},  32'(wrap_count),   32'(wc));
        chk({tag, ".err"},   32'(seq_err),      32'(er));
        chk({tag, ".state"}, 32'(fsm_state),    32'(st));
    endtask

    initial begin
        reset = 1'b0; count_vld = 1'b0; count_in = 2'd0; err_clr = 1'b0;
        #2;

        // T1: reset then idle
        cyc(1, 0, 0, 0);
        chk_all("t1_reset", 4'b0000, 0, 8'd0, 0, 2'b00);
        cyc(0, 0, 0, 0);
        chk_all("t1_idle", 4'b0000, 0, 8'd0, 0, 2'b00);

        // T2: legal 0,1,2,3,0
        cyc(0, 1, 0, 0); chk_all("t2_s0", 4'b0001, 0, 8'd0, 0, 2'b01);
        cyc(0, 1, 1, 0); chk_all("t2_s1", 4'b0010, 0, 8'd0, 0, 2'b01);
        cyc(0, 1, 2, 0); chk_all("t2_s2", 4'b0100, 0, 8'd0, 0, 2'b01);
        cyc(0, 1, 3, 0); chk_all("t2_s3", 4'b1000, 0, 8'd0, 0, 2'b01);
        cyc(0, 1, 0, 0); chk_all("t2_wrap", 4'b0001, 1, 8'd1, 0, 2'b01);
        cyc(0, 0, 0, 0); chk_all("t2_gap", 4'b0001, 0, 8'd1, 0, 2'b01);

        // T3: 1 then 3 is illegal (delta 2)
        cyc(0, 1, 1, 0); chk_all("t3_s1", 4'b0010, 0, 8'd1, 0, 2'b01);
        cyc(0, 1, 3, 0); chk_all("t3_bad", 4'b1000, 0, 8'd1, 1, 2'b10);
        cyc(0, 1, 0, 0);
        cyc(0, 1, 1, 0);
        cyc(0, 1, 2, 0);
        cyc(0, 1, 3, 0);
        cyc(0, 1, 0, 0); chk_all("t3_fault", 4'b0001, 0, 8'd1, 1, 2'b10);
        cyc(0, 0, 0, 1); chk_all("t3_clr", 4'b0001, 0, 8'd1, 0, 2'b00);
        cyc(0, 1, 1, 0); chk_all("t3_resync", 4'b0010, 0, 8'd1, 0, 2'b01);
        // clear coincident with an illegal step (1->3): clear wins
        cyc(0, 1, 3, 1); chk_all("t3_clr_wins", 4'b1000, 0, 8'd1, 0, 2'b00);
        // SYNC -> TRACK with an arbitrary first sample
        cyc(0, 1, 2, 0); chk_all("t3_sync2", 4'b0100, 0, 8'd1, 0, 2'b01);
        // a clear cycle with a valid sample: phase tracks, no check
        cyc(0, 1, 0, 1); chk_all("t3_clr_vld", 4'b0001, 0, 8'd1, 0, 2'b00);

        // T4: count held at 2 with gaps
        for (int i = 0; i < 5; i++) begin
            cyc(0, 1, 2, 0);
            chk("t4_pulse", 32'(wrap_pulse), 32'd0);
            cyc(0, 0, 1, 0);
        end
        chk_all("t4_hold", 4'b0100, 0, 8'd1, 0, 2'b01);

        // T6: build wrap_count to 5, stop at count 2, then reset
        cyc(0, 1, 3, 0);
        cyc(0, 1, 0, 0); chk_all("t6_w2", 4'b0001, 1, 8'd2, 0, 2'b01);
        for (int k = 0; k < 3; k++) begin
            cyc(0, 1, 1, 0); cyc(0, 1, 2, 0); cyc(0, 1, 3, 0); cyc(0, 1, 0, 0);
        end
        cyc(0, 1, 1, 0);
        cyc(0, 1, 2, 0); chk_all("t6_pre", 4'b0100, 0, 8'd5, 0, 2'b01);
        cyc(1, 1, 3, 1); chk_all("t6_reset", 4'b0000, 0, 8'd0, 0, 2'b00);
        // first sample after reset is 2 (delta 2 from prev 0) but unchecked in SYNC
        cyc(0, 1, 2, 0); chk_all("t6_first", 4'b0100, 0, 8'd0, 0, 2'b01);
        cyc(0, 1, 3, 0); chk_all("t6_next", 4'b1000, 0, 8'd0, 0, 2'b01);

        // T5: four full wraps on both widths
        cyc(1, 0, 0, 0);
        chk("t5_rst_small_wcnt", 32'(s_wrap_count), 32'd0);
        cyc(0, 1, 0, 0);
        for (int k = 0; k < 3; k++) begin
            cyc(0, 1, 1, 0); cyc(0, 1, 2, 0); cyc(0, 1, 3, 0); cyc(0, 1, 0, 0);
        end
        chk("t5_small_w3", 32'(s_wrap_count), 32'd3);
        chk("t5_big_w3", 32'(wrap_count), 32'd3);
        cyc(0, 1, 1, 0); cyc(0, 1, 2, 0); cyc(0, 1, 3, 0); cyc(0, 1, 0, 0);
`ifdef MOD4_MON_SAT_EN
        chk("t5_small_w4", 32'(s_wrap_count), 32'd3);
`else
        chk("t5_small_w4", 32'(s_wrap_count), 32'd0);
`endif
        chk("t5_small_pulse", 32'(s_wrap_pulse), 32'd1);
        chk("t5_big_w4", 32'(wrap_count), 32'd4);
        chk("t5_small_err", 32'(s_seq_err), 32'd0);
        cyc(0, 0, 0, 0);
        chk("t5_small_pulse_off", 32'(s_wrap_pulse), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
